sseg_disp_ctrl: RTL and testbench

SSEG_DISP_CTRL -- requirements
Module: sseg_disp_ctrl

---
 rtl/sseg_disp_ctrl.sv | 110 +++++++++++
 tb/tb_sseg_disp_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_disp_ctrl.sv
// Seven-segment display controller: eight 6-bit digit registers written
// by two round-robin arbitrated requesters. A scroll rotator feeds the
// registers out to the sseg_driver inputs.
module sseg_disp_ctrl #(
  parameter int SCROLL_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] addr_a,
  input  logic [2:0] addr_b,
  input  logic [5:0] data_a,
  input  logic [5:0] data_b,
  output logic       gnt_a,
  output logic       gnt_b,
  input  logic       clr,
  input  logic       scroll_en,
  output logic [5:0] out0,
  output logic [5:0] out1,
  output logic [5:0] out2,
  output logic [5:0] out3,
  output logic [5:0] out4,
  output logic [5:0] out5,
  output logic [5:0] out6,
  output logic [5:0] out7,
  output logic       scroll_step
);

  localparam logic [15:0] TICK_MAX = 16'(SCROLL_DIV - 1);

  logic [5:0]  r_regs [8];
  logic        r_ptr_b;   // 0: favour A on contention, 1: favour B
  logic [15:0] r_tick;
  logic [2:0]  r_off;
  logic        w_tick_wrap;

  // Arbitration: a sole requester always wins; contention is resolved by the pointer.
  // Grants are suppressed during clear and while reset is held.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst && !clr) begin
      if (req_a && req_b) begin
        gnt_a = !r_ptr_b;
        gnt_b = r_ptr_b;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Scroll step fires on the last tick of each period while scrolling is enabled.
  always_comb begin
    w_tick_wrap = scroll_en && (r_tick == TICK_MAX);
    scroll_step = rst && w_tick_wrap;
  end

  // Digit register file: the clear takes precedence; otherwise at most one granted write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (gnt_a) begin
      r_regs[addr_a] <= data_a;
    end else if (gnt_b) begin
      r_regs[addr_b] <= data_b;
    end
  end

  // Round-robin pointer: after any grant, favour the side that was not granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr_b <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      r_ptr_b <= gnt_a;
    end
  end

  // Scroll tick counter and rotation offset. Both are independent of clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick <= '0;
      r_off  <= '0;
    end else if (!scroll_en) begin
      r_tick <= '0;
      r_off  <= '0;
    end else if (w_tick_wrap) begin
      r_tick <= '0;
      r_off  <= r_off + 3'd1;
    end else begin
      r_tick <= r_tick + 16'd1;
    end
  end

  // Rotated view: the 3-bit index add wraps modulo 8 by construction.
  always_comb begin
    out0 = r_regs[r_off + 3'd0];
    out1 = r_regs[r_off + 3'd1];
    out2 = r_regs[r_off + 3'd2];
    out3 = r_regs[r_off + 3'd3];
    out4 = r_regs[r_off + 3'd4];
    out5 = r_regs[r_off + 3'd5];
    out6 = r_regs[r_off + 3'd6];
    out7 = r_regs[r_off + 3'd7];
  end

endmodule

// File: tb/tb_sseg_disp_ctrl.sv
// Directed testbench for sseg_disp_ctrl with SCROLL_DIV = 4.
module tb_sseg_disp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, clr, scroll_en;
  logic [2:0] addr_a, addr_b;
  logic [5:0] data_a, data_b;
  logic       gnt_a, gnt_b, scroll_step;
  logic [5:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [5:0] outs [8];

  int checks   = 0;
  int failures = 0;

  sseg_disp_ctrl #(.SCROLL_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .clr(clr), .scroll_en(scroll_en),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .scroll_step(scroll_step)
  );

  always #5 clk = ~clk;

  always_comb begin
    outs[0] = out0; outs[1] = out1; outs[2] = out2; outs[3] = out3;
    outs[4] = out4; outs[5] = out5; outs[6] = out6; outs[7] = out7;
  end

  // Advance one clock; inputs are then driven 1 ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_regs();
    for (int i = 0; i < 8; i++) begin
      req_a = 1'b1; addr_a = 3'(i); data_a = 6'(i);
      next_cycle();
    end
    req_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1; addr_a = 3'd2; addr_b = 3'd3;
    data_a = 6'd9; data_b = 6'd10; clr = 1'b0; scroll_en = 1'b1;
    next_cycle(); next_cycle();
    checks++;
    if ({gnt_a, gnt_b} !== 2'b00) begin
      failures++; $display("FAIL reset_gnt got=%b exp=00", {gnt_a, gnt_b});
    end
    checks++;
    if (scroll_step !== 1'b0) begin
      failures++; $display("FAIL reset_step got=%b exp=0", scroll_step);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (outs[k] !== 6'd0) begin
        failures++; $display("FAIL reset_out%0d got=%0d exp=0", k, outs[k]);
      end
    end
    req_a = 1'b0; req_b = 1'b0; scroll_en = 1'b0;
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_a();
    for (int i = 0; i < 8; i++) begin
      req_a = 1'b1; addr_a = 3'(i); data_a = 6'(i);
      #1;
      checks++;
      if ({gnt_a, gnt_b} !== 2'b10) begin
        failures++; $display("FAIL write_a_gnt%0d got=%b exp=10", i, {gnt_a, gnt_b});
      end
      next_cycle();
    end
    req_a = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (outs[k] !== 6'(k)) begin
        failures++; $display("FAIL write_a_out%0d got=%0d exp=%0d", k, outs[k], k);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    // fresh reset so the pointer favours A
    rst = 1'b0; #1; rst = 1'b1;
    next_cycle();
    req_a = 1'b1; req_b = 1'b1; addr_a = 3'd0; addr_b = 3'd1;
    data_a = 6'd11; data_b = 6'd22;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({gnt_a, gnt_b} !== exp_g[c]) begin
        failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", c, {gnt_a, gnt_b}, exp_g[c]);
      end
      next_cycle();
    end
    req_a = 1'b0; req_b = 1'b0;
    #1;
    checks++;
    if (out0 !== 6'd11) begin
      failures++; $display("FAIL rr_reg0 got=%0d exp=11", out0);
    end
    checks++;
    if (out1 !== 6'd22) begin
      failures++; $display("FAIL rr_reg1 got=%0d exp=22", out1);
    end
    // pointer now favours A, but a sole B request must still win
    req_b = 1'b1; addr_b = 3'd2; data_b = 6'd33;
    #1;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      failures++; $display("FAIL sole_b_gnt got=%b exp=01", {gnt_a, gnt_b});
    end
    next_cycle();
    req_b = 1'b0;
    #1;
    checks++;
    if (out2 !== 6'd33) begin
      failures++; $display("FAIL sole_b_reg2 got=%0d exp=33", out2);
    end
  endtask

  task automatic test_scroll();
    load_regs();
    scroll_en = 1'b1;
    for (int c = 0; c < 32; c++) begin
      #1;
      checks++;
      if (scroll_step !== ((c % 4) == 3)) begin
        failures++; $display("FAIL scroll_step_c%0d got=%b exp=%b", c, scroll_step, (c % 4) == 3);
      end
      checks++;
      if (out0 !== 6'((c / 4) % 8)) begin
        failures++; $display("FAIL scroll_out0_c%0d got=%0d exp=%0d", c, out0, (c / 4) % 8);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (out0 !== 6'd0 || out7 !== 6'd7) begin
      failures++; $display("FAIL scroll_wrap got=%0d/%0d exp=0/7", out0, out7);
    end
    scroll_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_scroll_write();
    scroll_en = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    req_a = 1'b1; addr_a = 3'd3; data_a = 6'd42;
    #1;
    checks++;
    if ({scroll_step, gnt_a} !== 2'b11) begin
      failures++; $display("FAIL sw_same_cycle got=%b exp=11", {scroll_step, gnt_a});
    end
    next_cycle();
    req_a = 1'b0;
    #1;
    checks++;
    if (out2 !== 6'd42) begin
      failures++; $display("FAIL sw_out2 got=%0d exp=42", out2);
    end
    checks++;
    if (out0 !== 6'd1) begin
      failures++; $display("FAIL sw_out0 got=%0d exp=1", out0);
    end
    scroll_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_clr();
    scroll_en = 1'b1;
    for (int c = 0; c < 4; c++) next_cycle();
    // offset 1, tick 0
    clr = 1'b1; req_a = 1'b1; addr_a = 3'd0; data_a = 6'd5;
    #1;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b00) begin
      failures++; $display("FAIL clr_gnt got=%b exp=00", {gnt_a, gnt_b});
    end
    next_cycle();
    clr = 1'b0; req_a = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (outs[k] !== 6'd0) begin
        failures++; $display("FAIL clr_out%0d got=%0d exp=0", k, outs[k]);
      end
    end
    req_a = 1'b1; addr_a = 3'd0; data_a = 6'd9;
    next_cycle();
    req_a = 1'b0;
    #1;
    checks++;
    if (out7 !== 6'd9) begin
      failures++; $display("FAIL clr_offset_kept got=%0d exp=9", out7);
    end
    checks++;
    if (scroll_step !== 1'b0) begin
      failures++; $display("FAIL clr_tick2_step got=%b exp=0", scroll_step);
    end
    next_cycle();
    #1;
    checks++;
    if (scroll_step !== 1'b1) begin
      failures++; $display("FAIL clr_tick3_step got=%b exp=1", scroll_step);
    end
    scroll_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_rst_mid_scroll();
    load_regs();
    scroll_en = 1'b1;
    for (int c = 0; c < 20; c++) next_cycle();
    #1;
    checks++;
    if (out0 !== 6'd5) begin
      failures++; $display("FAIL mid_pre_out0 got=%0d exp=5", out0);
    end
    req_a = 1'b1; addr_a = 3'd4; data_a = 6'd50;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt_a, gnt_b, scroll_step} !== 3'b000) begin
      failures++; $display("FAIL mid_rst_ctl got=%b exp=000", {gnt_a, gnt_b, scroll_step});
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (outs[k] !== 6'd0) begin
        failures++; $display("FAIL mid_rst_out%0d got=%0d exp=0", k, outs[k]);
      end
    end
    req_a = 1'b0;
    next_cycle();
    rst = 1'b1;
    req_a = 1'b1; addr_a = 3'd1; data_a = 6'd7;
    next_cycle();
    req_a = 1'b0;
    #1;
    checks++;
    if (out1 !== 6'd7 || out4 !== 6'd0) begin
      failures++; $display("FAIL mid_rst_offset0 got=%0d/%0d exp=7/0", out1, out4);
    end
    scroll_en = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_round_robin();
    test_scroll();
    test_scroll_write();
    test_clr();
    test_rst_mid_scroll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
